uart_tx_param: RTL

Parametrised UART serial transmitter that replaces the fixed-mode transmitter. Data width, parity, stop bits, bit order, baud divisor and CTS/RTS flow control are elaboration-time parameters, not a hardwired mode byte. Parallel words arrive over a valid/ready handshake from the upstream buffer or memory reader. The block drives the serial line DATA_OUT and RTS at the chip boundary.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_baud_counter.sv | 40 ++++
 rtl/uart_tx_param.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART blocks. Holds the
//                transmitter state encoding, the parity-mode constants, the
//                standard baud divisors for a 100 MHz clock, and a clog2
//                helper used to size counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Clock cycles per bit at 100 MHz
    localparam int DIV_9600   = 10416;
    localparam int DIV_19200  = 5208;
    localparam int DIV_38400  = 2604;
    localparam int DIV_115200 = 868;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_counter
//  Description : Restartable bit-period counter. Counts 0..CLKS_PER_BIT-1,
//                flags the last cycle of each bit period and wraps to 0 so a
//                state spanning several bit periods keeps its timing.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                i_restart  - hold the counter at 0
//                o_bit_end  - high in the final cycle of a bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DIV_115200
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_bit_end
);

    localparam int                 c_cnt_w = clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;

    assign o_bit_end = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (rst || i_restart || o_bit_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parametrised UART transmitter. Accepts words over a
//                valid/ready handshake and serialises them as
//                start / data / optional parity / 1-2 stop bits, with
//                optional CTS gating of frame start and RTS generation.
//  Ports       : Clock      - clock, rising edge
//                Reset      - synchronous active-high reset
//                TX_DATA    - word to send, taken on handshake
//                TX_VALID   - upstream word available
//                TX_READY   - word accepted this cycle when TX_VALID high
//                CTS        - clear-to-send, asynchronous
//                DATA_OUT   - serial line, idles high
//                RTS        - request-to-send
//                BUSY       - frame in progress
//                FRAME_DONE - pulse in the last cycle of the last stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = DIV_115200,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = PAR_EVEN,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0,
    parameter int FLOW_CTRL    = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    input  logic                 CTS,
    output logic                 DATA_OUT,
    output logic                 RTS,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int                 c_idx_w    = clog2(DATA_BITS);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic                 r_parity;
    logic                 r_stop_idx;
    logic                 r_cts_meta;
    logic                 r_cts_sync;
    logic                 r_rts;

    logic                 w_cts_s;
    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_frame_end;
    logic                 w_handshake;
    logic                 w_tx_bit;

    // CTS is asynchronous to Clock; two flops before use.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cts_meta <= 1'b0;
            r_cts_sync <= 1'b0;
        end else begin
            r_cts_meta <= CTS;
            r_cts_sync <= r_cts_meta;
        end
    end

    assign w_cts_s = (FLOW_CTRL != 0) ? r_cts_sync : 1'b1;

    // Held at 0 while idle so the START bit gets a full period; every other
    // transition happens on bit_end, where the counter wraps to 0 anyway.
    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (Clock),
        .rst       (Reset),
        .i_restart (r_state == ST_IDLE),
        .o_bit_end (w_bit_end)
    );

    assign w_last_stop = (STOP_BITS == 2) ? r_stop_idx : 1'b1;
    assign w_frame_end = (r_state == ST_STOP) && w_bit_end && w_last_stop;
    assign w_tx_bit    = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];
    assign w_handshake = TX_VALID && TX_READY;

    // State register and frame datapath
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_parity   <= 1'b0;
            r_stop_idx <= 1'b0;
            r_rts      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rts   <= (FLOW_CTRL != 0) && (TX_VALID || BUSY);

            if (w_handshake) begin
                r_shift    <= TX_DATA;
                r_bit_idx  <= '0;
                r_parity   <= 1'b0;
                r_stop_idx <= 1'b0;
            end else if (w_bit_end) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= (MSB_FIRST != 0) ? {r_shift[DATA_BITS-2:0], 1'b0}
                                                      : {1'b0, r_shift[DATA_BITS-1:1]};
                        r_parity  <= r_parity ^ w_tx_bit;
                        r_bit_idx <= (r_bit_idx == c_idx_last) ? '0 : r_bit_idx + 1'b1;
                    end
                    ST_STOP: begin
                        // Toggles 0->1->0 over two stop bits, ends at 0 either way.
                        r_stop_idx <= (STOP_BITS == 2) ? ~r_stop_idx : 1'b0;
                        if (w_last_stop) begin
                            r_parity <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_idx == c_idx_last)) begin
                    w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_frame_end) begin
                    w_state_next = w_handshake ? ST_START : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        TX_READY   = w_cts_s && !Reset && ((r_state == ST_IDLE) || w_frame_end);
        BUSY       = (r_state != ST_IDLE);
        FRAME_DONE = w_frame_end;
        RTS        = r_rts;
        DATA_OUT   = 1'b1;
        case (r_state)
            ST_START:  DATA_OUT = 1'b0;
            ST_DATA:   DATA_OUT = w_tx_bit;
            ST_PARITY: DATA_OUT = (PARITY_ODD == PAR_ODD) ? ~r_parity : r_parity;
            default:   DATA_OUT = 1'b1;
        endcase
    end

endmodule
`default_nettype wire
